bisr_spare_remap: RTL and testbench
===================================

# bisr_spare_remap

Parametrised built-in self-repair remapper that sits between the user port and the main SRAM array of the memory controller. During BIST it collects failing word addresses into a small table of spare registers. Once armed, it redirects every access to a logged address into that spare storage, and it blocks the corresponding main-array access. It generalises the fixed spare-register repair to configurable address width, data width and spare count, and adds duplicate suppression, an occupancy count and an overflow flag.

## Interface
- ADDR_W, 16: word address width; the top 6 bits select the macro, the low 10 bits select the word.
- DATA_W, 8: data width.
- N_SPARE, 4: number of spare entries (≥1).
- CLK  in  1  system clock; all state changes on the rising edge.
- RSTN  in  1  reset, asynchronous and active-low.
- FAIL_VLD  in  1  BIST presents a failing address.
- FAIL_ADDR  in  ADDR_W  failing address.
- FAIL_RDY  out  1  table accepts a fault this cycle.
- BIST_DONE  in  1  one-cycle pulse that freezes the table and arms remapping.
- CLR  in  1  synchronous clear of the whole table back to collection.
- CSB  in  1  user chip select, active-low.
- WEB  in  1  user write enable, active-low.
- OEB  in  1  user output enable, active-low.
- ADDR  in  ADDR_W  user address.
- IDATA  in  DATA_W  user write data.
- MEM_CSB  out  1  chip select to the main array.
- MEM_ODATA  in  DATA_W  main-array read data, valid one cycle after a read edge.
- ODATA  out  DATA_W  read data returned to the user.
- HIT  out  1  registered; the last sampled access was served by a spare.
- USED  out  $clog2(N_SPARE+1)  number of allocated entries.
- REPAIR_FAIL  out  1  sticky; a fault arrived with no free spare left.
- LOCKED  out  1  remapping is armed.

## Operation

States and transitions:
- COLLECT → ARMED on BIST_DONE.
- ARMED → COLLECT on CLR.
- CLR in COLLECT clears the table and stays in COLLECT.
- Reset enters COLLECT.

Fault logging, in COLLECT only:
- FAIL_RDY = (state == COLLECT) and not CLR.
- A fault is accepted when FAIL_VLD and FAIL_RDY are both high at the edge.
- The accepted FAIL_ADDR is compared against all valid entries.
  - On a match it is dropped, and nothing else changes.
  - On no match with USED < N_SPARE, entry[USED] is written with valid=1, addr=FAIL_ADDR and data=0, and USED increments.
  - On no match with USED == N_SPARE, REPAIR_FAIL is set and the table is unchanged.

Remapping, in ARMED only:
- The combinational hit is CSB==0, LOCKED, and ADDR equal to the address of some valid entry.
- MEM_CSB = CSB | hit, so the main array is never touched for a repaired address.
- On a hit write (WEB=0), the entry data takes IDATA at the edge.
- On a hit read (WEB=1, OEB=0), HIT_q is set and the entry data is captured into spare_q.
- On any other sampled access, HIT_q is cleared.
- With CSB high, HIT_q holds its value.
- ODATA = HIT_q ? spare_q : MEM_ODATA.

Priority and boundary cases:
- CLR has priority over BIST_DONE, which has priority over FAIL_VLD.
- CLR clears every valid bit and resets USED, REPAIR_FAIL, LOCKED and HIT_q.
- If FAIL_VLD and BIST_DONE arrive in the same cycle, the fault is logged before locking.
- BIST_DONE while already in ARMED is ignored.
- FAIL_VLD while in ARMED is ignored, with FAIL_RDY low.
- Addresses are compared on all ADDR_W bits; entries never overlap because duplicates are suppressed.

## Timing
- Reset values:
  - outputs: FAIL_RDY=1, HIT=0, USED=0, REPAIR_FAIL=0, LOCKED=0, MEM_CSB=CSB, ODATA=MEM_ODATA.
  - internal state: all entries invalid with data 0.
- Fault logging latency is 1 cycle: USED reflects an accepted fault at the next edge.
- LOCKED rises at the edge that samples BIST_DONE.
- Read latency is 1 cycle for both paths, so a repaired address looks identical to an unrepaired one from the user side.
- Write followed by a read of the same repaired address on the next cycle returns the new data.
- MEM_CSB is combinational from ADDR and CSB, so the main array samples it at the same edge as the user access.

## Structure
- Package bisr_pkg holds:
  - the state enum (COLLECT, ARMED);
  - a USED_W localparam function of N_SPARE.
- Sub-module bisr_spare_entry, instantiated N_SPARE times, holds:
  - valid, addr and data registers;
  - an address comparator, with a load port for allocation and a write port for user data.
- The top level holds:
  - the FSM;
  - the allocation counter;
  - the one-hot hit OR and the data mux.

## Test plan
- Reset, N_SPARE=4, log 16'hF658, 16'hECC8, 16'hDA58 → USED=3, REPAIR_FAIL=0, FAIL_RDY=1.
- Log 16'h002E twice, then 16'h0034 → USED=2, and the duplicate causes no allocation.
- N_SPARE=2, log three distinct addresses → USED=2, REPAIR_FAIL=1 sticky until CLR.
- After BIST_DONE:
  - write 8'hA5 to 16'hF658 → MEM_CSB stays 1;
  - read it back → next cycle HIT=1, ODATA=8'hA5;
  - read unrepaired 16'h1000 → HIT=0, ODATA=MEM_ODATA.
- FAIL_VLD together with BIST_DONE on a new address → logged, USED increments, LOCKED=1; a later FAIL_VLD is ignored.
- Assert CLR in ARMED, and separately assert RSTN low mid-read → USED=0, LOCKED=0, HIT=0, previously repaired addresses go to the main array.

Source files
------------

// File: rtl/bisr_pkg.sv
// Shared types and sizing helpers for the spare-register repair remapper.
//   bisr_state_e : COLLECT (logging faults) / ARMED (remapping user accesses)
//   used_w()     : width of the occupancy counter for a given spare count
package bisr_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    ARMED   = 1'b1
  } bisr_state_e;

  localparam int DEF_N_SPARE = 4;

  // The counter must hold 0..n inclusive.
  function automatic int used_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_USED_W = used_w(DEF_N_SPARE);

endpackage

// File: rtl/bisr_spare_entry.sv
// One spare register: valid/addr/data plus two address comparators.
//   clr        : drop the entry (valid and data back to 0)
//   load       : allocate this entry for load_addr with data 0
//   wr_en      : user write into the spare data
//   fail_addr  : compared for duplicate suppression -> fail_match
//   user_addr  : compared for remapping              -> user_match
//   data       : stored spare word
module bisr_spare_entry #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] fail_addr,
  input  logic [ADDR_W-1:0] user_addr,
  output logic              fail_match,
  output logic              user_match,
  output logic [DATA_W-1:0] data
);

  logic              valid;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= '0;
    end else if (wr_en) begin
      data  <= wr_data;
    end
  end

  assign fail_match = valid && (addr == fail_addr);
  assign user_match = valid && (addr == user_addr);

endmodule

// File: rtl/bisr_spare_remap.sv
// Built-in self-repair remapper between the user port and the main SRAM.
// In COLLECT, failing addresses from BIST are logged (duplicates dropped)
// into N_SPARE spare entries. BIST_DONE arms remapping: any access to a
// logged address is served from the spare and the main array is deselected.
//   fail_vld/fail_addr/fail_rdy : fault logging handshake
//   bist_done, clr              : arm / clear back to collection
//   csb/web/oeb/addr/idata      : user port (active-low controls)
//   mem_csb, mem_odata          : main array select and read data
//   odata, hit                  : user read data, registered spare-hit flag
//   used, repair_fail, locked   : occupancy, sticky overflow, armed status
module bisr_spare_remap
  import bisr_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int N_SPARE = DEF_N_SPARE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fail_vld,
  input  logic [ADDR_W-1:0]            fail_addr,
  output logic                         fail_rdy,
  input  logic                         bist_done,
  input  logic                         clr,
  input  logic                         csb,
  input  logic                         web,
  input  logic                         oeb,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            idata,
  output logic                         mem_csb,
  input  logic [DATA_W-1:0]            mem_odata,
  output logic [DATA_W-1:0]            odata,
  output logic                         hit,
  output logic [used_w(N_SPARE)-1:0]   used,
  output logic                         repair_fail,
  output logic                         locked
);

  localparam int UW = used_w(N_SPARE);

  bisr_state_e state_q, state_d;

  logic [N_SPARE-1:0]             fail_match, user_match, load, wr_en;
  logic [N_SPARE-1:0][DATA_W-1:0] ent_data;
  logic                           fail_acc, dup, full, alloc, overflow;
  logic                           acc_hit, rd_hit;
  logic [DATA_W-1:0]              spare_rd, spare_q;
  logic                           hit_q;

  // FSM: CLR outranks BIST_DONE; BIST_DONE in ARMED is a no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (bist_done) state_d = ARMED;
      ARMED:   state_d = ARMED;
      default: state_d = COLLECT;
    endcase
    if (clr) state_d = COLLECT;
  end

  assign locked   = (state_q == ARMED);
  assign fail_rdy = (state_q == COLLECT) && !clr;

  // Fault logging. A fault sampled together with BIST_DONE is still in
  // COLLECT at that edge, so it gets logged before the lock takes effect.
  assign fail_acc = fail_vld && fail_rdy;
  assign dup      = |fail_match;
  assign full     = (used == UW'(N_SPARE));
  assign alloc    = fail_acc && !dup && !full;
  assign overflow = fail_acc && !dup && full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used        <= '0;
      repair_fail <= 1'b0;
    end else if (clr) begin
      used        <= '0;
      repair_fail <= 1'b0;
    end else begin
      if (alloc)    used        <= used + 1'b1;
      if (overflow) repair_fail <= 1'b1;
    end
  end

  // Remap hit; entries never overlap, so user_match is one-hot or zero.
  assign acc_hit = !csb && locked && |user_match;
  assign rd_hit  = acc_hit && web && !oeb;
  assign mem_csb = csb | acc_hit;

  genvar g;
  generate
    for (g = 0; g < N_SPARE; g++) begin : g_ent
      // Entries fill in order, so the next free slot is entry[used].
      assign load[g]  = alloc && (used == UW'(g));
      assign wr_en[g] = acc_hit && !web && user_match[g];

      bisr_spare_entry #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_ent (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (load[g]),
        .load_addr  (fail_addr),
        .wr_en      (wr_en[g]),
        .wr_data    (idata),
        .fail_addr  (fail_addr),
        .user_addr  (addr),
        .fail_match (fail_match[g]),
        .user_match (user_match[g]),
        .data       (ent_data[g])
      );
    end
  endgenerate

  always_comb begin
    spare_rd = '0;
    for (int i = 0; i < N_SPARE; i++)
      if (user_match[i]) spare_rd |= ent_data[i];
  end

  // Spare read path is registered so it lines up with the 1-cycle SRAM
  // read latency; hit_q holds while deselected so odata stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= 1'b0;
      spare_q <= '0;
    end else if (clr) begin
      hit_q   <= 1'b0;
    end else if (!csb) begin
      hit_q <= rd_hit;
      if (rd_hit) spare_q <= spare_rd;
    end
  end

  assign hit   = hit_q;
  assign odata = hit_q ? spare_q : mem_odata;

endmodule

// File: tb/tb_bisr_spare_remap.sv
module tb_bisr_spare_remap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fail_vld, bist_done, clr, csb, web, oeb;
  logic [15:0] fail_addr, addr;
  logic [7:0]  idata;
  logic [7:0]  mem_odata = 8'h00;

  logic        fail_rdy, mem_csb, hit, repair_fail, locked;
  logic [7:0]  odata;
  logic [2:0]  used;

  logic        fail_rdy2, mem_csb2, hit2, repair_fail2, locked2;
  logic [7:0]  odata2;
  logic [1:0]  used2;

  always #5 clk = ~clk;

  bisr_spare_remap #(.ADDR_W(16), .DATA_W(8), .N_SPARE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .fail_vld(fail_vld), .fail_addr(fail_addr),
    .fail_rdy(fail_rdy), .bist_done(bist_done), .clr(clr), .csb(csb),
    .web(web), .oeb(oeb), .addr(addr), .idata(idata), .mem_csb(mem_csb),
    .mem_odata(mem_odata), .odata(odata), .hit(hit), .used(used),
    .repair_fail(repair_fail), .locked(locked)
  );

  bisr_spare_remap #(.ADDR_W(16), .DATA_W(8), .N_SPARE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .fail_vld(fail_vld), .fail_addr(fail_addr),
    .fail_rdy(fail_rdy2), .bist_done(bist_done), .clr(clr), .csb(csb),
    .web(web), .oeb(oeb), .addr(addr), .idata(idata), .mem_csb(mem_csb2),
    .mem_odata(mem_odata), .odata(odata2), .hit(hit2), .used(used2),
    .repair_fail(repair_fail2), .locked(locked2)
  );

  // Main-array model: read data is addr[7:0]^8'h3C, one cycle after the edge.
  always @(posedge clk)
    if (!mem_csb && web) mem_odata <= addr[7:0] ^ 8'h3C;

  typedef enum int {K_USED, K_RF, K_RDY, K_LOCK, K_HIT, K_ODATA, K_ODMEM,
                    K_MCSB, K_USED2, K_RF2} kind_e;
  typedef struct {
    int    cyc;
    kind_e kind;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input kind_e k, input int v, input int dly, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.kind = k; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, pops every expectation due now.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        int act;
        int req;
        req = q[i].val;
        case (q[i].kind)
          K_USED:  act = int'(used);
          K_RF:    act = int'(repair_fail);
          K_RDY:   act = int'(fail_rdy);
          K_LOCK:  act = int'(locked);
          K_HIT:   act = int'(hit);
          K_ODATA: act = int'(odata);
          K_ODMEM: begin act = int'(odata); req = int'(mem_odata); end
          K_MCSB:  act = int'(mem_csb);
          K_USED2: act = int'(used2);
          K_RF2:   act = int'(repair_fail2);
          default: act = -1;
        endcase
        n_chk++;
        if (q[i].cyc != cyc)
          $display("FAIL %s: check missed its cycle (due %0d, now %0d)", q[i].name, q[i].cyc, cyc);
        else if (act != req)
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", q[i].name, act, req, cyc);
        else
          n_pass++;
        q.delete(i);
      end
    end
  end

  task automatic log_fault(input logic [15:0] a);
    fail_vld = 1'b1; fail_addr = a;
    tick;
    fail_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fail_vld = 1'b0; bist_done = 1'b0; clr = 1'b0;
    csb = 1'b1; web = 1'b1; oeb = 1'b1; addr = '0; idata = '0; fail_addr = '0;
    tick; tick;
    rst_n = 1'b1;
    // Reset state
    expect_at(K_USED, 0, 0, "rst_used");
    expect_at(K_RF,   0, 0, "rst_repair_fail");
    expect_at(K_RDY,  1, 0, "rst_fail_rdy");
    expect_at(K_LOCK, 0, 0, "rst_locked");
    expect_at(K_HIT,  0, 0, "rst_hit");
    expect_at(K_MCSB, 1, 0, "rst_mem_csb");
    expect_at(K_ODMEM, 0, 0, "rst_odata_mem");

    // Three distinct faults: N=4 holds them, N=2 overflows
    log_fault(16'hF658); log_fault(16'hECC8); log_fault(16'hDA58);
    expect_at(K_USED, 3, 0, "log3_used");
    expect_at(K_RF,   0, 0, "log3_repair_fail");
    expect_at(K_RDY,  1, 0, "log3_fail_rdy");
    expect_at(K_USED2, 2, 0, "n2_used_full");
    expect_at(K_RF2,   1, 0, "n2_repair_fail");
    tick;
    expect_at(K_RF2, 1, 0, "n2_repair_fail_sticky");
    clr = 1'b1;
    expect_at(K_RDY, 0, 0, "clr_fail_rdy_low");
    tick;
    clr = 1'b0;
    expect_at(K_USED, 0, 0, "clr_used");
    expect_at(K_RF2,  0, 0, "clr_n2_repair_fail");

    // Duplicate suppression
    log_fault(16'h002E); log_fault(16'h002E); log_fault(16'h0034);
    expect_at(K_USED,  2, 0, "dup_used");
    expect_at(K_USED2, 2, 0, "dup_used_n2");
    expect_at(K_RF2,   0, 0, "dup_n2_no_overflow");
    clr = 1'b1; tick; clr = 1'b0;

    // Fault together with BIST_DONE is logged, then locked
    log_fault(16'hF658); log_fault(16'hECC8);
    fail_vld = 1'b1; fail_addr = 16'hDA58; bist_done = 1'b1;
    expect_at(K_RDY, 1, 0, "done_cycle_fail_rdy");
    tick;
    fail_vld = 1'b0; bist_done = 1'b0;
    expect_at(K_USED, 3, 0, "done_used");
    expect_at(K_LOCK, 1, 0, "done_locked");
    expect_at(K_RF2,  1, 0, "done_n2_overflow");
    fail_vld = 1'b1; fail_addr = 16'h5555;
    expect_at(K_RDY, 0, 0, "armed_fail_rdy_low");
    tick;
    fail_vld = 1'b0;
    expect_at(K_USED, 3, 0, "armed_fault_ignored");

    // Remapped write, then read back
    csb = 1'b0; web = 1'b0; oeb = 1'b1; addr = 16'hF658; idata = 8'hA5;
    expect_at(K_MCSB, 1, 0, "wr_repaired_mem_csb");
    tick;
    web = 1'b1; oeb = 1'b0;
    expect_at(K_MCSB, 1, 0, "rd_repaired_mem_csb");
    expect_at(K_HIT,   1,     1, "rd_repaired_hit");
    expect_at(K_ODATA, 8'hA5, 1, "rd_repaired_odata");
    tick;
    csb = 1'b1;
    expect_at(K_HIT,   1,     1, "idle_hit_hold");
    expect_at(K_ODATA, 8'hA5, 1, "idle_odata_hold");
    tick;
    csb = 1'b0; addr = 16'h1000;
    expect_at(K_MCSB, 0, 0, "rd_plain_mem_csb");
    expect_at(K_HIT,   0,     1, "rd_plain_hit");
    expect_at(K_ODATA, 8'h3C, 1, "rd_plain_odata");
    tick;
    addr = 16'hECC8;
    expect_at(K_HIT,   1,     1, "rd_unwritten_spare_hit");
    expect_at(K_ODATA, 8'h00, 1, "rd_unwritten_spare_odata");
    tick;

    // CLR while armed
    csb = 1'b1; clr = 1'b1;
    tick;
    clr = 1'b0;
    expect_at(K_USED, 0, 0, "armed_clr_used");
    expect_at(K_LOCK, 0, 0, "armed_clr_locked");
    expect_at(K_HIT,  0, 0, "armed_clr_hit");
    expect_at(K_RDY,  1, 0, "armed_clr_fail_rdy");
    csb = 1'b0; web = 1'b1; oeb = 1'b0; addr = 16'hF658;
    expect_at(K_MCSB, 0, 0, "after_clr_mem_csb");
    tick;
    csb = 1'b1;
    expect_at(K_HIT,   0,     0, "after_clr_hit");
    expect_at(K_ODATA, 8'h64, 0, "after_clr_odata");

    // Reset asserted in the middle of a repaired read
    fail_vld = 1'b1; fail_addr = 16'hF658; bist_done = 1'b1;
    tick;
    fail_vld = 1'b0; bist_done = 1'b0;
    csb = 1'b0; web = 1'b1; oeb = 1'b0; addr = 16'hF658;
    expect_at(K_LOCK, 1, 0, "relock_locked");
    expect_at(K_MCSB, 1, 0, "relock_mem_csb");
    tick;
    expect_at(K_HIT, 1, 0, "relock_hit");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    expect_at(K_HIT,   0, 1, "midrd_rst_hit");
    expect_at(K_USED,  0, 1, "midrd_rst_used");
    expect_at(K_LOCK,  0, 1, "midrd_rst_locked");
    expect_at(K_MCSB,  0, 1, "midrd_rst_mem_csb");
    expect_at(K_ODMEM, 0, 1, "midrd_rst_odata");
    tick; tick;
    rst_n = 1'b1; csb = 1'b1;
    tick; tick; tick;

    for (int i = 0; i < q.size(); i++) begin
      n_chk++;
      $display("FAIL %s: never checked (due cycle %0d)", q[i].name, q[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
